// File: rtl/mux_scan_pkg.sv
// Shared definitions for the mux channel-scan sequencer.
// Used by mux_scan_ctrl and mux_settle_timer.
package mux_scan_pkg;

   localparam int unsigned StateW    = 2;
   localparam int unsigned SettleMax = 15;
   localparam int unsigned CntW      = 4;

   typedef enum logic [StateW-1:0] {
      StIdle = 2'd0,
      StScan = 2'd1,
      StDone = 2'd2
   } scan_state_e;

endpackage

// File: rtl/mux_settle_timer.sv
// Load/decrement settle counter; counts down to zero and holds there.
// zero is combinational from the count.
module mux_settle_timer
   import mux_scan_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [CntW-1:0] value,
   output logic            zero
);

   logic [CntW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = value;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_ctrl.sv
// Channel-scan sequencer driving a mux select, sampling its output into a word
// presented with valid/ready. Define MUX_SCAN_AUTO_EN for back-to-back scans.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned SETTLE = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   output logic [$clog2(NUM_CH)-1:0] sel,
   input  logic                      mux_out,
   output logic [NUM_CH-1:0]         data,
   output logic                      valid,
   input  logic                      ready,
   output logic                      busy
);

   localparam int unsigned SEL_W = $clog2(NUM_CH);
   localparam logic [SEL_W-1:0] LastSel = SEL_W'(NUM_CH - 1);
   // Out-of-range SETTLE is clamped to what the counter can hold.
   localparam logic [CntW-1:0] SettleVal =
      CntW'((SETTLE > SettleMax) ? SettleMax : SETTLE);

   scan_state_e         state_q, state_d;
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [NUM_CH-1:0]   shadow_q, shadow_d;
   logic [NUM_CH-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                tmr_load;
   logic                tmr_zero;

   mux_settle_timer u_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tmr_load),
      .value (SettleVal),
      .zero  (tmr_zero)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      data_d   = data_q;
      valid_d  = valid_q;
      tmr_load = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               sel_d    = '0;
               shadow_d = '0;
               tmr_load = 1'b1;
               state_d  = StScan;
            end
         end
         StScan: begin
            if (tmr_zero) begin
               shadow_d[sel_q] = mux_out;
               if (sel_q == LastSel) begin
                  // Merge the final sample directly; shadow_q lacks it yet.
                  data_d        = shadow_q;
                  data_d[sel_q] = mux_out;
                  valid_d       = 1'b1;
                  state_d       = StDone;
               end else begin
                  sel_d    = sel_q + 1'b1;
                  tmr_load = 1'b1;
               end
            end
         end
         StDone: begin
            if (valid_q && ready) begin
               valid_d = 1'b0;
`ifdef MUX_SCAN_AUTO_EN
               sel_d    = '0;
               shadow_d = '0;
               tmr_load = 1'b1;
               state_d  = StScan;
`else
               state_d  = StIdle;
`endif
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sel_q    <= '0;
         shadow_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         data_q   <= data_d;
         valid_q  <= valid_d;
      end
   end

   assign sel   = sel_q;
   assign data  = data_q;
   assign valid = valid_q;
   assign busy  = (state_q != StIdle);

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Channel-scan sequencer that sits directly upstream of `mux_4x1` and drives its `sel` input. It also consumes the mux's `out` on the return path. On a start request it steps `sel` through every channel, waits a programmable settle time on each, and samples the mux output. The samples are assembled into a parallel word, which is presented downstream with a valid/ready handshake.

## Interface
- `NUM_CH`, default 4: number of mux channels. Power of two, range 2..16.
- `SETTLE`, default 1: extra wait cycles after each `sel` change before sampling. Range 0..15.
- `SEL_W` (localparam): `$clog2(NUM_CH)`.
- One clock; reset is asynchronous and active-low.
- `clk` input 1: system clock. All logic runs on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: scan request, sampled only in IDLE.
- `sel` output SEL_W: channel select to the mux.
- `mux_out` input 1: mux output, the returned sample.
- `data` output NUM_CH: assembled word; bit i holds channel i.
- `valid` output 1: `data` is complete and stable.
- `ready` input 1: downstream accepts `data`.
- `busy` output 1: high in SCAN or DONE.

## Operation
- FSM states:
  - IDLE=0
  - SCAN=1
  - DONE=2
- IDLE:
  - If `start` is high at an edge: `sel` <= 0, settle counter <= SETTLE, shadow register <= 0, state -> SCAN.
- SCAN, on each edge:
  - If counter != 0: decrement.
  - Else: shadow[sel] <= `mux_out`.
  - If `sel` == NUM_CH-1: `data` <= shadow with `mux_out` merged at bit `sel`; `valid` <= 1; state -> DONE; `sel` holds.
  - Otherwise: `sel` <= `sel`+1 and counter <= SETTLE.
- DONE:
  - Hold `valid`, `data` and `sel`.
  - When `valid` and `ready` are both high at an edge: `valid` <= 0, state -> IDLE.
- `start` is ignored in SCAN and DONE. There is no queuing; a pulse landing there is lost.
- `data` changes only on the edge that raises `valid`. It holds its value until the next completed scan, including while in IDLE.
- `sel` is never incremented past NUM_CH-1; no wrap-around is allowed during a scan.
- Reset values (asynchronous assertion, synchronous release):
  - state = IDLE
  - `sel` = 0
  - `data` = 0
  - `valid` = 0
  - `busy` = 0
  - counter = 0
  - shadow = 0
- Reset during SCAN or DONE discards the partial or pending word. No `valid` is produced afterwards.

## Timing
- Each channel occupies SETTLE+1 cycles in SCAN.
- Latency: `valid` rises NUM_CH*(SETTLE+1) edges after the edge that accepts `start`. With defaults this is 8 edges.
- `sel` is registered. Channel i is sampled at the last edge of its slot, so the mux has SETTLE+1 full cycles to settle.
- `ready` may already be high when `valid` rises. The transfer completes on the next edge, so `valid` is high for at least 1 cycle.
- `ready` without `valid` has no effect.
- `busy` is combinational from state. It goes high the cycle after `start` is accepted and low the cycle after the handshake.
- Minimum start-to-start period, with `ready` tied high: NUM_CH*(SETTLE+1)+2 cycles.

## Configuration
- Macro: `MUX_SCAN_AUTO_EN`.
- Defined: on the handshake edge in DONE, the FSM goes directly to SCAN instead of IDLE. It reloads `sel`=0, counter=SETTLE and shadow=0, giving continuous back-to-back scans. `start` is then needed only for the first scan, and `busy` stays high.
- Undefined: behaviour is exactly as in Operation; each scan requires a new `start`.

## Structure
- Shared package `mux_scan_pkg`:
  - state encodings IDLE/SCAN/DONE
  - state width (2)
  - SETTLE maximum (15) and counter width (4)
- Sub-module `mux_settle_timer`:
  - load/decrement counter
  - `load` and `value` inputs
  - `zero` flag output
- FSM, `sel` register, shadow register and handshake logic live in the top level.

## Test plan
- Default parameters, with `mux_4x1` connected to `sel`/`mux_out` and `in`=4'b1010. Pulse `start` -> `sel` steps 0,1,2,3, holding 2 cycles each; `valid` rises 8 edges after start; `data`=4'b1010.
- Same setup, hold `ready`=0 for 5 cycles after `valid` -> `valid`, `data`=4'b1010 and `sel`=3 stay stable; `valid` falls one edge after `ready` rises; `busy` falls with it.
- Set `in`=4'b0110 and pulse `start` again mid-scan, at cycle 3 -> second start ignored; single result `data`=4'b0110 at edge 8.
- Assert `rst_n`=0 at cycle 5 of a scan -> `sel`, `data`, `valid`, `busy` all 0 immediately; no `valid` after release.
- SETTLE=0, `in`=4'b1111 -> `valid` after 4 edges, `data`=4'b1111. With `MUX_SCAN_AUTO_EN` and `ready`=1: a new `valid` every 5 cycles, and changing `in` to 4'b0001 appears in the next word.
